// File: rtl/pipe_compare_monitor.sv
// Self-checking monitor comparing a non-blocking and a blocking 2-stage pipeline
// against an ideal history of their shared input, counting mismatches per run.
module pipe_compare_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned N_SAMPLES = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_nb,
  input  logic [WIDTH-1:0] c_nb,
  input  logic [WIDTH-1:0] b_blk,
  input  logic [WIDTH-1:0] c_blk,
  output logic             busy,
  output logic             mismatch_nb,
  output logic             mismatch_blk,
  output logic [CNT_W-1:0] mis_nb_cnt,
  output logic [CNT_W-1:0] mis_blk_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             done,
  output logic             pass
);

  localparam int unsigned       CHK_W    = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CHK_W-1:0]  LAST_CHK = CHK_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_d1, a_d2;
  logic               fill_cnt, fill_nxt;
  // Run length tracked separately so a narrow, saturating sample_cnt cannot stall the run.
  logic [CHK_W-1:0]   chk_cnt, chk_nxt;
  logic [CNT_W-1:0]   mis_nb_cnt_nxt, mis_blk_cnt_nxt, sample_cnt_nxt;
  logic               mismatch_nb_nxt, mismatch_blk_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic               mis_nb_c, mis_blk_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Unknown inputs must register as mismatches, hence the case inequality.
  always_comb begin
    mis_nb_c  = (b_nb  !== a_d1) || (c_nb  !== a_d2);
    mis_blk_c = (b_blk !== a_d1) || (c_blk !== a_d2);
  end

  // State register plus history and run datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      a_d1         <= '0;
      a_d2         <= '0;
      fill_cnt     <= 1'b0;
      chk_cnt      <= '0;
      mis_nb_cnt   <= '0;
      mis_blk_cnt  <= '0;
      sample_cnt   <= '0;
      mismatch_nb  <= 1'b0;
      mismatch_blk <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state        <= state_nxt;
      a_d1         <= a;
      a_d2         <= a_d1;
      fill_cnt     <= fill_nxt;
      chk_cnt      <= chk_nxt;
      mis_nb_cnt   <= mis_nb_cnt_nxt;
      mis_blk_cnt  <= mis_blk_cnt_nxt;
      sample_cnt   <= sample_cnt_nxt;
      mismatch_nb  <= mismatch_nb_nxt;
      mismatch_blk <= mismatch_blk_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pass         <= pass_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (fill_cnt) state_nxt = CHECK;
      CHECK:   if (chk_cnt == LAST_CHK) state_nxt = DONE;
      DONE:    if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of counters and registered outputs
  always_comb begin
    fill_nxt         = fill_cnt;
    chk_nxt          = chk_cnt;
    mis_nb_cnt_nxt   = mis_nb_cnt;
    mis_blk_cnt_nxt  = mis_blk_cnt;
    sample_cnt_nxt   = sample_cnt;
    mismatch_nb_nxt  = 1'b0;
    mismatch_blk_nxt = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          fill_nxt        = 1'b0;
          chk_nxt         = '0;
          mis_nb_cnt_nxt  = '0;
          mis_blk_cnt_nxt = '0;
          sample_cnt_nxt  = '0;
        end
      end
      FILL: fill_nxt = fill_cnt + 1'b1;
      CHECK: begin
        chk_nxt        = chk_cnt + CHK_W'(1);
        sample_cnt_nxt = sat_inc(sample_cnt);
        if (mis_nb_c) begin
          mis_nb_cnt_nxt  = sat_inc(mis_nb_cnt);
          mismatch_nb_nxt = 1'b1;
        end
        if (mis_blk_c) begin
          mis_blk_cnt_nxt  = sat_inc(mis_blk_cnt);
          mismatch_blk_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt == FILL) || (state_nxt == CHECK);
    done_nxt = (state_nxt == DONE);
    pass_nxt = done_nxt && (mis_nb_cnt_nxt == '0);
  end

endmodule

// File: tb/tb_pipe_compare_monitor.sv
// Directed bench: reference pipelines feed the monitor; a second instance with
// narrow counters and a permanent stage-1 fault exercises saturation.
module tb_pipe_compare_monitor;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             fault;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b_nb_q = '0, c_nb_q = '0, b_blk_q = '0, c_blk_q = '0;
  logic [WIDTH-1:0] c_nb_in, b_nb_sat;

  logic       busy, mismatch_nb, mismatch_blk, done, pass;
  logic [7:0] mis_nb_cnt, mis_blk_cnt, sample_cnt;
  logic       s_busy, s_mismatch_nb, s_mismatch_blk, s_done, s_pass;
  logic [1:0] s_mis_nb_cnt, s_mis_blk_cnt, s_sample_cnt;

  int checks = 0;
  int failures = 0;
  int pulses_nb, pulses_blk;
  logic [WIDTH-1:0] stim [5] = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};

  always #5 clk = ~clk;

  // Non-blocking reference: b<=a; c<=b
  always @(posedge clk) begin
    b_nb_q <= a;
    c_nb_q <= b_nb_q;
  end

  // Blocking variant collapses to c taking the new b, i.e. both stages load a
  always @(posedge clk) begin
    b_blk_q <= a;
    c_blk_q <= a;
  end

  assign c_nb_in  = fault ? '0 : c_nb_q;
  assign b_nb_sat = ~b_nb_q;

  pipe_compare_monitor #(.WIDTH(WIDTH), .N_SAMPLES(5), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .b_nb(b_nb_q), .c_nb(c_nb_in), .b_blk(b_blk_q), .c_blk(c_blk_q),
    .busy(busy), .mismatch_nb(mismatch_nb), .mismatch_blk(mismatch_blk),
    .mis_nb_cnt(mis_nb_cnt), .mis_blk_cnt(mis_blk_cnt), .sample_cnt(sample_cnt),
    .done(done), .pass(pass)
  );

  pipe_compare_monitor #(.WIDTH(WIDTH), .N_SAMPLES(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .b_nb(b_nb_sat), .c_nb(c_nb_q), .b_blk(b_blk_q), .c_blk(c_blk_q),
    .busy(s_busy), .mismatch_nb(s_mismatch_nb), .mismatch_blk(s_mismatch_blk),
    .mis_nb_cnt(s_mis_nb_cnt), .mis_blk_cnt(s_mis_blk_cnt), .sample_cnt(s_sample_cnt),
    .done(s_done), .pass(s_pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then stream 3,7,F,A,2 and hold 2; optional fault / ignored restart
  task automatic do_run(input int fault_k, input int restart_k);
    pulses_nb  = 0;
    pulses_blk = 0;
    start = 1'b1;
    a = '0;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_sample_clr", 32'(sample_cnt), 32'd0);
    check("start_mis_nb_clr", 32'(mis_nb_cnt), 32'd0);
    check("start_mis_blk_clr", 32'(mis_blk_cnt), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      a = (k <= 5) ? stim[k-1] : 4'h2;
      fault = (k == fault_k);
      start = (k == restart_k);
      step();
      fault = 1'b0;
      start = 1'b0;
      pulses_nb  += int'(mismatch_nb);
      pulses_blk += int'(mismatch_blk);
      if (k == 6) begin
        check("done_not_early", 32'(done), 32'd0);
        check("busy_in_check", 32'(busy), 32'd1);
        check("sat_done_not_early", 32'(s_done), 32'd0);
      end
    end
    check("done_at_7", 32'(done), 32'd1);
    check("busy_clear_in_done", 32'(busy), 32'd0);
    check("sample_cnt", 32'(sample_cnt), 32'd5);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    fault = 1'b0;
    a = '0;

    // Reset held with activity on inputs
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom);
      start = ~start;
      step();
    end
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mm_nb", 32'(mismatch_nb), 32'd0);
    check("rst_mm_blk", 32'(mismatch_blk), 32'd0);
    check("rst_counts", 32'({mis_nb_cnt, mis_blk_cnt, sample_cnt}), 32'd0);
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'($urandom);
      step();
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Ideal run: non-blocking clean, blocking misses 4; saturating instance in parallel
    do_run(0, 0);
    check("r1_mis_nb", 32'(mis_nb_cnt), 32'd0);
    check("r1_pulses_nb", 32'(pulses_nb), 32'd0);
    check("r1_mis_blk", 32'(mis_blk_cnt), 32'd4);
    check("r1_pulses_blk", 32'(pulses_blk), 32'd4);
    check("r1_pass", 32'(pass), 32'd1);
    check("sat_mis_nb", 32'(s_mis_nb_cnt), 32'd3);
    check("sat_sample", 32'(s_sample_cnt), 32'd3);
    check("sat_mis_blk", 32'(s_mis_blk_cnt), 32'd3);
    check("sat_done", 32'(s_done), 32'd1);
    check("sat_pass", 32'(s_pass), 32'd0);
    step();
    check("done_hold", 32'(done), 32'd1);
    check("done_cnt_hold", 32'(mis_blk_cnt), 32'd4);
    check("done_no_pulse", 32'(mismatch_blk), 32'd0);

    // Restart from DONE with one-cycle c_nb fault and a start during CHECK
    do_run(4, 5);
    check("r2_mis_nb", 32'(mis_nb_cnt), 32'd1);
    check("r2_pulses_nb", 32'(pulses_nb), 32'd1);
    check("r2_pass", 32'(pass), 32'd0);
    check("r2_mis_blk", 32'(mis_blk_cnt), 32'd4);

    // Asynchronous reset during CHECK
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a = stim[k-1];
      step();
    end
    check("pre_abort_blk", 32'(mis_blk_cnt), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_counts", 32'({mis_nb_cnt, mis_blk_cnt, sample_cnt}), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    #2 rst = 1'b1;
    step();
    check("post_abort_idle", 32'(busy), 32'd0);

    do_run(0, 0);
    check("r3_mis_nb", 32'(mis_nb_cnt), 32'd0);
    check("r3_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
